// File: rtl/avalon_to_wb_bridge.sv
// Avalon-MM slave to Wishbone B4 master bridge: single/burst reads and writes, retry and error handling.
// Optional macro AV2WB_ERR_RESPONSE_EN adds s_av_response_o (SLVERR for reads ended by wb_err_i).
module avalon_to_wb_bridge #(
    parameter int DW  = 32,
    parameter int AW  = 32,
    parameter int BCW = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [AW-1:0]     s_av_address_i,
    input  logic [DW-1:0]     s_av_writedata_i,
    input  logic [DW/8-1:0]   s_av_byteenable_i,
    input  logic              s_av_read_i,
    input  logic              s_av_write_i,
    input  logic [BCW-1:0]    s_av_burstcount_i,
    output logic [DW-1:0]     s_av_readdata_o,
    output logic              s_av_readdatavalid_o,
    output logic              s_av_waitrequest_o,
`ifdef AV2WB_ERR_RESPONSE_EN
    output logic [1:0]        s_av_response_o,
`endif
    output logic [AW-1:0]     wb_adr_o,
    output logic [DW-1:0]     wb_dat_o,
    output logic [DW/8-1:0]   wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic [2:0]        wb_cti_o,
    output logic [1:0]        wb_bte_o,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i,
    input  logic              wb_rty_i
);

    localparam int              SW       = DW / 8;
    localparam logic [AW-1:0]   ADR_STEP = AW'(SW);
    localparam logic [BCW-1:0]  BC_ONE   = {{(BCW-1){1'b0}}, 1'b1};
    localparam logic [BCW-1:0]  BC_ZERO  = {BCW{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD      = 2'd1,
        WR      = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     adr_q, adr_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic [2:0]        cti_q, cti_d;
    logic [BCW-1:0]    beats_left_q, beats_left_d;
    logic              burst_q, burst_d;
    logic              retry_q, retry_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
`ifdef AV2WB_ERR_RESPONSE_EN
    logic [1:0]        resp_q, resp_d;
`endif

    logic              term_s;
    logic              rty_s;
    logic              last_s;
    logic [BCW-1:0]    bc_eff_s;
    logic              bc_multi_s;
    logic [BCW-1:0]    left_dec_s;

    // Cycle type for the beat about to be issued, given the beats remaining after it.
    function automatic logic [2:0] next_cti(input logic burst, input logic [BCW-1:0] remaining);
        logic [2:0] cti;
        if (!burst) begin
            cti = 3'b000;
        end else if (remaining == BC_ZERO) begin
            cti = 3'b111;
        end else begin
            cti = 3'b010;
        end
        return cti;
    endfunction

    // Beat termination: err has priority over ack, and rty only counts when neither is present.
    always_comb begin
        term_s     = cyc_q & stb_q & (wb_ack_i | wb_err_i);
        rty_s      = cyc_q & stb_q & wb_rty_i & ~wb_ack_i & ~wb_err_i;
        last_s     = (beats_left_q == BC_ZERO);
        bc_eff_s   = (s_av_burstcount_i == BC_ZERO) ? BC_ONE : s_av_burstcount_i;
        bc_multi_s = (bc_eff_s != BC_ONE);
        left_dec_s = beats_left_q - BC_ONE;
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a write presented together with a read takes precedence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (s_av_write_i) begin
                    state_d = WR;
                end else if (s_av_read_i) begin
                    state_d = RD;
                end else begin
                    state_d = IDLE;
                end
            end
            RD: begin
                if (term_s && last_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD;
                end
            end
            WR: begin
                if (term_s) begin
                    state_d = last_s ? IDLE : WR_DATA;
                end else begin
                    state_d = WR;
                end
            end
            WR_DATA: begin
                if (s_av_write_i) begin
                    state_d = WR;
                end else begin
                    state_d = WR_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered bus outputs.
    always_comb begin
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        we_d         = we_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        cti_d        = cti_q;
        beats_left_d = beats_left_q;
        burst_d      = burst_q;
        retry_d      = 1'b0;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
`ifdef AV2WB_ERR_RESPONSE_EN
        resp_d       = resp_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_av_write_i) begin
                    adr_d        = s_av_address_i;
                    dat_d        = s_av_writedata_i;
                    sel_d        = s_av_byteenable_i;
                    beats_left_d = bc_eff_s - BC_ONE;
                    burst_d      = bc_multi_s;
                    cti_d        = bc_multi_s ? 3'b010 : 3'b000;
                    cyc_d        = 1'b1;
                    stb_d        = 1'b1;
                    we_d         = 1'b1;
                end else if (s_av_read_i) begin
                    adr_d        = s_av_address_i;
                    beats_left_d = bc_eff_s - BC_ONE;
                    burst_d      = bc_multi_s;
                    cti_d        = bc_multi_s ? 3'b010 : 3'b000;
                    cyc_d        = 1'b1;
                    stb_d        = 1'b1;
                    we_d         = 1'b0;
                end else begin
                    cyc_d = 1'b0;
                    stb_d = 1'b0;
                end
            end
            RD: begin
                if (term_s) begin
                    rdata_d  = wb_dat_i;
                    rvalid_d = 1'b1;
                    adr_d    = adr_q + ADR_STEP;
`ifdef AV2WB_ERR_RESPONSE_EN
                    resp_d   = wb_err_i ? 2'b10 : 2'b00;
`endif
                    if (last_s) begin
                        cyc_d = 1'b0;
                        stb_d = 1'b0;
                        cti_d = 3'b000;
                    end else begin
                        beats_left_d = left_dec_s;
                        cti_d        = next_cti(burst_q, left_dec_s);
                    end
                end else if (rty_s) begin
                    stb_d   = 1'b0;
                    retry_d = 1'b1;
                end else if (retry_q) begin
                    stb_d = 1'b1;
                end else begin
                    stb_d = stb_q;
                end
            end
            WR: begin
                if (term_s) begin
                    adr_d = adr_q + ADR_STEP;
                    stb_d = 1'b0;
                    if (last_s) begin
                        cyc_d = 1'b0;
                        we_d  = 1'b0;
                        cti_d = 3'b000;
                    end else begin
                        cyc_d = 1'b1;
                    end
                end else if (rty_s) begin
                    stb_d   = 1'b0;
                    retry_d = 1'b1;
                end else if (retry_q) begin
                    stb_d = 1'b1;
                end else begin
                    stb_d = stb_q;
                end
            end
            WR_DATA: begin
                if (s_av_write_i) begin
                    dat_d        = s_av_writedata_i;
                    sel_d        = s_av_byteenable_i;
                    beats_left_d = left_dec_s;
                    cti_d        = next_cti(burst_q, left_dec_s);
                    stb_d        = 1'b1;
                end else begin
                    stb_d = 1'b0;
                end
            end
            default: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                we_d  = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            adr_q        <= {AW{1'b0}};
            dat_q        <= {DW{1'b0}};
            sel_q        <= {SW{1'b0}};
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            cti_q        <= 3'b000;
            beats_left_q <= BC_ZERO;
            burst_q      <= 1'b0;
            retry_q      <= 1'b0;
            rdata_q      <= {DW{1'b0}};
            rvalid_q     <= 1'b0;
`ifdef AV2WB_ERR_RESPONSE_EN
            resp_q       <= 2'b00;
`endif
        end else begin
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            cti_q        <= cti_d;
            beats_left_q <= beats_left_d;
            burst_q      <= burst_d;
            retry_q      <= retry_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
`ifdef AV2WB_ERR_RESPONSE_EN
            resp_q       <= resp_d;
`endif
        end
    end

    // Waitrequest follows the state so it is also forced high throughout reset.
    assign s_av_waitrequest_o   = ~wb_rst_n_i | (state_q == RD) | (state_q == WR);
    assign s_av_readdata_o      = rdata_q;
    assign s_av_readdatavalid_o = rvalid_q;
`ifdef AV2WB_ERR_RESPONSE_EN
    assign s_av_response_o      = resp_q;
`endif
    assign wb_adr_o             = adr_q;
    assign wb_dat_o             = dat_q;
    assign wb_sel_o             = sel_q;
    assign wb_we_o              = we_q;
    assign wb_cyc_o             = cyc_q;
    assign wb_stb_o             = stb_q;
    assign wb_cti_o             = cti_q;
    assign wb_bte_o             = 2'b00;

endmodule
